// File: rtl/delay_line_pkg.sv
// Shared constants, state encoding and helpers for the tap output stage.
// DELAY_ECHO_MIX_EN (see delay_tap_out_stage) does not affect anything here.
package delay_line_pkg;
  localparam int DATA_W    = 8;
  localparam int MAX_DEPTH = 90;

  localparam int TAP_D30 = 30;
  localparam int TAP_D45 = 45;
  localparam int TAP_D60 = 60;
  localparam int TAP_D90 = 90;

  localparam logic [7:0] SEL_T30 = 8'd0;
  localparam logic [7:0] SEL_T45 = 8'd1;
  localparam logic [7:0] SEL_T60 = 8'd2;
  localparam logic [7:0] SEL_T90 = 8'd3;

  localparam int FILL_W = 7;
  localparam int HCNT_W = 4;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_RUN,
    ST_HOLD,
    ST_MUTE
  } state_e;

  function automatic logic sel_valid(input logic [7:0] s);
    return s <= SEL_T90;
  endfunction
endpackage

// File: rtl/delay_fill_tracker.sv
// Counts clocks since reset (saturating at MAX_DEPTH) and flags which taps
// have seen enough samples to carry real data.
module delay_fill_tracker #(
  parameter int MAX_DEPTH = delay_line_pkg::MAX_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] primed
);
  import delay_line_pkg::*;

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_DEPTH);

  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    if (fill_q < FILL_MAX) fill_d = fill_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= '0;
    else        fill_q <= fill_d;
  end

  assign primed[0] = fill_q >= FILL_W'(TAP_D30);
  assign primed[1] = fill_q >= FILL_W'(TAP_D45);
  assign primed[2] = fill_q >= FILL_W'(TAP_D60);
  assign primed[3] = fill_q >= FILL_W'(TAP_D90);
endmodule

// File: rtl/delay_tap_out_stage.sv
// Tap select / output stage: blanks output while taps fill, after a tap change
// and on invalid selects. DELAY_ECHO_MIX_EN mixes the dry input into RUN output.
module delay_tap_out_stage #(
  parameter int DATA_W    = delay_line_pkg::DATA_W,
  parameter int HOLD_CYC  = 2,
  parameter int MAX_DEPTH = delay_line_pkg::MAX_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] tap_30,
  input  logic [DATA_W-1:0] tap_45,
  input  logic [DATA_W-1:0] tap_60,
  input  logic [DATA_W-1:0] tap_90,
  input  logic [7:0]        sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              sel_err,
  output logic [7:0]        switch_cnt
);
  import delay_line_pkg::*;

  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        sel_q, sel_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [3:0]        primed;
  logic [DATA_W-1:0] tap_sel, run_val;
  logic              sel_ok, sel_chg, tap_rdy;
  logic [7:0]        cnt_inc;

  delay_fill_tracker #(.MAX_DEPTH(MAX_DEPTH)) u_fill (
    .clk    (clk),
    .rst_n  (rst_n),
    .primed (primed)
  );

  always_comb begin
    case (sel[1:0])
      2'd0:    tap_sel = tap_30;
      2'd1:    tap_sel = tap_45;
      2'd2:    tap_sel = tap_60;
      default: tap_sel = tap_90;
    endcase
  end

`ifdef DELAY_ECHO_MIX_EN
  logic [DATA_W:0] mix_sum;
  assign mix_sum = {1'b0, data_in} + {1'b0, tap_sel} + {{DATA_W{1'b0}}, 1'b1};
  assign run_val = mix_sum[DATA_W:1];
`else
  logic unused_data;
  assign unused_data = ^data_in;
  assign run_val     = tap_sel;
`endif

  assign sel_ok  = sel_valid(sel);
  assign sel_chg = sel != sel_q;
  assign tap_rdy = primed[sel[1:0]];
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Priority: invalid code, then any switch (incl. leaving MUTE), then per-state flow.
  always_comb begin
    state_d = state_q;
    sel_d   = sel;
    hcnt_d  = hcnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (!sel_ok) begin
      state_d = ST_MUTE;
      hcnt_d  = '0;
      dout_d  = '0;
      err_d   = 1'b1;
    end else if (state_q == ST_MUTE || sel_chg) begin
      state_d = ST_HOLD;
      hcnt_d  = '0;
      cnt_d   = cnt_inc;
    end else begin
      case (state_q)
        ST_FILL, ST_RUN: begin
          if (tap_rdy) begin
            state_d = ST_RUN;
            dout_d  = run_val;
            vld_d   = 1'b1;
          end else begin
            state_d = ST_FILL;
            dout_d  = '0;
          end
        end
        ST_HOLD: begin
          if (hcnt_q >= HOLD_LAST) begin
            if (tap_rdy) begin
              state_d = ST_RUN;
              dout_d  = run_val;
              vld_d   = 1'b1;
            end else begin
              state_d = ST_FILL;
              dout_d  = '0;
            end
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      sel_q   <= '0;
      hcnt_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hcnt_q  <= hcnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign sel_err    = err_q;
  assign switch_cnt = cnt_q;
endmodule
